// File: rtl/nios_cpu_gpi_irq_ctrl.sv
// GPI controller for the Nios CPU: synchronizes and debounces board inputs, captures
// selected edges in a W1C register and raises a level interrupt, all configured over Avalon-MM.
module nios_cpu_gpi_irq_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT_W   = 16,
  parameter int DEB_DEFAULT = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  in_port,
  input  logic [2:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int INIT_W = $clog2(SYNC_STAGES + 1);

  state_t                               state, state_next;
  logic [INIT_W-1:0]                    init_cnt;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]    sync_q;
  logic [WIDTH-1:0]                     sync;
  logic [WIDTH-1:0]                     deb, deb_d;
  logic [WIDTH-1:0]                     irq_mask, rise_en, fall_en, edge_cap;
  logic [WIDTH-1:0]                     edge_set, cap_clr;
  logic [DEB_CNT_W-1:0]                 deb_per;
  logic [DEB_CNT_W-1:0]                 deb_cnt [WIDTH];
  logic                                 out_en;
  logic [31:0]                          rd_mux;
  logic                                 wr_mask, wr_cap, wr_sel, wr_per;
  logic                                 unused_wdata;

  assign wr_mask      = avs_write && (avs_address == 3'd2);
  assign wr_cap       = avs_write && (avs_address == 3'd3);
  assign wr_sel       = avs_write && (avs_address == 3'd4);
  assign wr_per       = avs_write && (avs_address == 3'd5);
  assign unused_wdata = ^avs_writedata;
  assign sync         = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
  end

  // INIT waits until the synchronizer holds real pin values before LOAD seeds the debouncer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) init_cnt <= init_cnt + INIT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (init_cnt == INIT_W'(SYNC_STAGES - 1)) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      deb_per  <= DEB_CNT_W'(DEB_DEFAULT);
    end else begin
      if (wr_mask) irq_mask <= avs_writedata[WIDTH-1:0];
      if (wr_sel) begin
        rise_en <= avs_writedata[WIDTH-1:0];
        fall_en <= avs_writedata[16 +: WIDTH];
      end
      if (wr_per) deb_per <= avs_writedata[DEB_CNT_W-1:0];
    end
  end

  // deb_d tracks the previous debounced value; seeding it at LOAD suppresses startup edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
    end else begin
      deb_d <= deb;
      if (state == ST_LOAD) begin
        deb   <= sync;
        deb_d <= sync;
        for (int i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
      end else if (wr_per) begin
        for (int i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
      end else if (state == ST_RUN) begin
        if (deb_per == '0) begin
          deb <= sync;
          for (int i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == deb[i]) begin
              deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == deb_per - DEB_CNT_W'(1)) begin
              deb[i]     <= sync[i];
              deb_cnt[i] <= '0;
            end else begin
              deb_cnt[i] <= deb_cnt[i] + DEB_CNT_W'(1);
            end
          end
        end
      end
    end
  end

  assign edge_set = (state == ST_RUN) ?
                    ((deb & ~deb_d & rise_en) | (~deb & deb_d & fall_en)) : '0;
  assign cap_clr  = wr_cap ? avs_writedata[WIDTH-1:0] : '0;

  // A new edge outranks a simultaneous W1C so no event is ever lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cap <= '0;
    else          edge_cap <= (edge_cap & ~cap_clr) | edge_set;
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      3'd0: rd_mux[WIDTH-1:0]     = deb;
      3'd1: rd_mux[WIDTH-1:0]     = sync;
      3'd2: rd_mux[WIDTH-1:0]     = irq_mask;
      3'd3: rd_mux[WIDTH-1:0]     = edge_cap;
      3'd4: begin
        rd_mux[WIDTH-1:0]  = rise_en;
        rd_mux[16 +: WIDTH] = fall_en;
      end
      3'd5: rd_mux[DEB_CNT_W-1:0] = deb_per;
      3'd6: begin
        rd_mux[0]   = irq;
        rd_mux[2:1] = state;
      end
      default: rd_mux = '0;
    endcase
  end

  // out_en holds both outputs at zero on the first edge after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_en       <= 1'b0;
      irq          <= 1'b0;
      avs_readdata <= '0;
    end else begin
      out_en       <= 1'b1;
      irq          <= out_en && |(edge_cap & irq_mask);
      avs_readdata <= out_en ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_nios_cpu_gpi_irq_ctrl.sv
// Self-checking bench for nios_cpu_gpi_irq_ctrl: directed scenarios plus randomized pin
// traffic compared against a run-length debounce/edge model.
module tb_nios_cpu_gpi_irq_ctrl;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int DEB_CNT_W   = 16;
  localparam int DEB_DEFAULT = 0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_port = '0;
  logic [2:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios_cpu_gpi_irq_ctrl #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .DEB_CNT_W(DEB_CNT_W), .DEB_DEFAULT(DEB_DEFAULT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_port(in_port),
    .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .irq(irq)
  );

  task automatic write_csr(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    avs_address = addr; avs_writedata = data; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic read_csr(input logic [2:0] addr, output logic [31:0] data);
    @(negedge clk);
    avs_address = addr;
    @(negedge clk);
    data = avs_readdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] st [4];
    in_port = 8'hA5; reset_n = 1'b0;
    #23;
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (avs_readdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", avs_readdata); end
    @(negedge clk); avs_address = 3'd6; reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin @(negedge clk); st[k] = avs_readdata; end
    checks++; if (st[0] !== 32'h0) begin errors++; $display("[TB] FAIL first_edge_rdata: got %h expected 0", st[0]); end
    checks++; if (st[2] !== 32'h2) begin errors++; $display("[TB] FAIL status_load: got %h expected 2", st[2]); end
    checks++; if (st[3] !== 32'h4) begin errors++; $display("[TB] FAIL status_run: got %h expected 4", st[3]); end
    repeat (3) @(negedge clk);
    read_csr(3'd0, rd);
    checks++; if (rd !== 32'hA5) begin errors++; $display("[TB] FAIL startup_data: got %h expected a5", rd); end
    read_csr(3'd1, rd);
    checks++; if (rd !== 32'hA5) begin errors++; $display("[TB] FAIL startup_raw: got %h expected a5", rd); end
    read_csr(3'd3, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL startup_cap: got %h expected 0", rd); end
    read_csr(3'd5, rd);
    checks++; if (rd !== 32'(DEB_DEFAULT)) begin errors++; $display("[TB] FAIL startup_debper: got %h expected %h", rd, DEB_DEFAULT); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL startup_irq: got %b expected 0", irq); end
  endtask

  task automatic test_debounce();
    logic [31:0] rd;
    logic prev;
    int toggles, falls;
    write_csr(3'd5, 32'd4);
    write_csr(3'd4, 32'h0001_0001);
    for (int plen = 3; plen <= 4; plen++) begin
      avs_address = 3'd0;
      @(negedge clk);
      prev = avs_readdata[0]; toggles = 0; falls = 0;
      for (int c = 0; c < 24; c++) begin
        @(negedge clk);
        in_port = (c < plen) ? 8'hA4 : 8'hA5;
        if (avs_readdata[0] !== prev) begin
          toggles++;
          if (prev === 1'b1) falls++;
        end
        prev = avs_readdata[0];
      end
      checks++; if (toggles !== 2 * (plen - 3)) begin errors++; $display("[TB] FAIL pulse%0d_toggles: got %0d expected %0d", plen, toggles, 2 * (plen - 3)); end
      checks++; if (falls !== plen - 3) begin errors++; $display("[TB] FAIL pulse%0d_falls: got %0d expected %0d", plen, falls, plen - 3); end
      read_csr(3'd3, rd);
      checks++; if (rd !== 32'(plen - 3)) begin errors++; $display("[TB] FAIL pulse%0d_cap: got %h expected %h", plen, rd, plen - 3); end
      write_csr(3'd3, 32'hFF);
    end
    read_csr(3'd0, rd);
    checks++; if (rd !== 32'hA5) begin errors++; $display("[TB] FAIL debounce_data: got %h expected a5", rd); end
    write_csr(3'd4, 32'h0);
    write_csr(3'd5, 32'h0);
  endtask

  task automatic test_edge_irq();
    logic [31:0] rd;
    int lat_irq, lat_cap;
    in_port = 8'h00;
    repeat (8) @(negedge clk);
    write_csr(3'd3, 32'hFF);
    write_csr(3'd4, 32'h0000_0008);
    write_csr(3'd2, 32'h08);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL pre_edge_irq: got %b expected 0", irq); end
    avs_address = 3'd3;
    @(negedge clk); in_port = 8'h08;
    lat_irq = -1; lat_cap = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (irq === 1'b1 && lat_irq < 0) lat_irq = c;
      if (avs_readdata[3] === 1'b1 && lat_cap < 0) lat_cap = c;
    end
    checks++; if (lat_irq !== SYNC_STAGES + 3) begin errors++; $display("[TB] FAIL irq_latency: got %0d expected %0d", lat_irq, SYNC_STAGES + 3); end
    checks++; if (lat_cap !== lat_irq) begin errors++; $display("[TB] FAIL cap_vs_irq: got %0d expected %0d", lat_cap, lat_irq); end
    checks++; if (avs_readdata !== 32'h08) begin errors++; $display("[TB] FAIL rise_cap: got %h expected 08", avs_readdata); end
    @(negedge clk); avs_address = 3'd3; avs_writedata = 32'h08; avs_write = 1'b1;
    @(negedge clk); avs_write = 1'b0;
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL w1c_irq_hold: got %b expected 1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL w1c_irq_drop: got %b expected 0", irq); end
    checks++; if (avs_readdata !== 32'h0) begin errors++; $display("[TB] FAIL w1c_cap: got %h expected 0", avs_readdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int drops;
    in_port = 8'h00; repeat (6) @(negedge clk);
    in_port = 8'h08; repeat (8) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL collide_setup_irq: got %b expected 1", irq); end
    in_port = 8'h00; repeat (6) @(negedge clk);
    @(negedge clk); in_port = 8'h08;
    repeat (3) @(negedge clk);
    avs_address = 3'd3; avs_writedata = 32'h08; avs_write = 1'b1;
    drops = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); avs_write = 1'b0;
      if (irq !== 1'b1) drops++;
    end
    checks++; if (drops !== 0) begin errors++; $display("[TB] FAIL collide_irq_drops: got %0d expected 0", drops); end
    read_csr(3'd3, rd);
    checks++; if (rd !== 32'h08) begin errors++; $display("[TB] FAIL collide_cap: got %h expected 08", rd); end
    write_csr(3'd3, 32'hFF);
  endtask

  task automatic test_fall();
    logic [31:0] rd;
    write_csr(3'd2, 32'h0);
    write_csr(3'd4, 32'h0004_0000);
    in_port = 8'h00; repeat (6) @(negedge clk);
    write_csr(3'd3, 32'hFF);
    in_port = 8'h04; repeat (8) @(negedge clk);
    read_csr(3'd3, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL fall_rise_ignored: got %h expected 0", rd); end
    in_port = 8'h00; repeat (8) @(negedge clk);
    read_csr(3'd3, rd);
    checks++; if (rd !== 32'h04) begin errors++; $display("[TB] FAIL fall_cap: got %h expected 04", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL fall_masked_irq: got %b expected 0", irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    write_csr(3'd2, 32'h04);
    write_csr(3'd5, 32'd7);
    write_csr(3'd4, 32'h0004_0004);
    @(negedge clk); avs_address = 3'd2; in_port = 8'h04;
    repeat (3) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL midreset_pre_irq: got %b expected 1", irq); end
    checks++; if (avs_readdata !== 32'h04) begin errors++; $display("[TB] FAIL midreset_pre_rdata: got %h expected 04", avs_readdata); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL midreset_irq: got %b expected 0", irq); end
    checks++; if (avs_readdata !== 32'h0) begin errors++; $display("[TB] FAIL midreset_rdata: got %h expected 0", avs_readdata); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    read_csr(3'd2, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL midreset_mask: got %h expected 0", rd); end
    read_csr(3'd4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL midreset_sel: got %h expected 0", rd); end
    read_csr(3'd5, rd);
    checks++; if (rd !== 32'(DEB_DEFAULT)) begin errors++; $display("[TB] FAIL midreset_debper: got %h expected %h", rd, DEB_DEFAULT); end
    read_csr(3'd3, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL midreset_cap: got %h expected 0", rd); end
    read_csr(3'd0, rd);
    checks++; if (rd !== 32'h04) begin errors++; $display("[TB] FAIL midreset_data: got %h expected 04", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [7:0]  samples[$];
    logic [7:0]  v0, rise, fall, mask, val, exp_deb, exp_cap;
    int          n, nseg, len;
    int          run [8];
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(0, 5);
      v0 = 8'($urandom); rise = 8'($urandom); fall = 8'($urandom); mask = 8'($urandom);
      write_csr(3'd5, 32'(n));
      write_csr(3'd4, 32'h0);
      write_csr(3'd2, 32'h0);
      in_port = v0;
      repeat (SYNC_STAGES + n + 6) @(negedge clk);
      write_csr(3'd3, 32'hFF);
      write_csr(3'd4, {8'h00, fall, 8'h00, rise});
      write_csr(3'd2, {24'h0, mask});
      samples.delete();
      nseg = $urandom_range(8, 15);
      val = v0;
      for (int s = 0; s < nseg; s++) begin
        val = 8'($urandom);
        len = $urandom_range(1, n + 3);
        for (int k = 0; k < len; k++) samples.push_back(val);
      end
      for (int k = 0; k < SYNC_STAGES + n + 6; k++) samples.push_back(val);
      foreach (samples[k]) begin
        @(negedge clk); in_port = samples[k];
      end
      // Model: a bit adopts the pin level once it has differed for n consecutive samples
      exp_deb = v0; exp_cap = '0;
      for (int b = 0; b < 8; b++) run[b] = 0;
      foreach (samples[k]) begin
        for (int b = 0; b < 8; b++) begin
          if (samples[k][b] == exp_deb[b]) begin
            run[b] = 0;
          end else begin
            run[b]++;
            if (run[b] >= n) begin
              exp_deb[b] = samples[k][b];
              run[b] = 0;
              if (exp_deb[b] && rise[b]) exp_cap[b] = 1'b1;
              if (!exp_deb[b] && fall[b]) exp_cap[b] = 1'b1;
            end
          end
        end
      end
      read_csr(3'd0, rd);
      checks++; if (rd !== {24'h0, exp_deb}) begin errors++; $display("[TB] FAIL rand%0d_data: got %h expected %h", it, rd, exp_deb); end
      read_csr(3'd3, rd);
      checks++; if (rd !== {24'h0, exp_cap}) begin errors++; $display("[TB] FAIL rand%0d_cap: got %h expected %h", it, rd, exp_cap); end
      read_csr(3'd5, rd);
      checks++; if (rd !== 32'(n)) begin errors++; $display("[TB] FAIL rand%0d_debper: got %h expected %h", it, rd, n); end
      checks++; if (irq !== |(exp_cap & mask)) begin errors++; $display("[TB] FAIL rand%0d_irq: got %b expected %b", it, irq, |(exp_cap & mask)); end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_debounce();
    test_edge_irq();
    test_back_to_back();
    test_fall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
